commit_write_buffer: RTL and testbench
======================================

# commit_write_buffer

Store-commit write buffer between the reorder buffer's memory-commit port (`we_mem`/`ws_mem`/`wd_mem`) and the data memory. Absorbs one committed store per cycle into a small FIFO and drains entries to memory over a req/ack handshake. Provides youngest-match forwarding to the load path so committed-but-undrained stores stay visible. It is the receiving end of the reorder buffer's data-cache write interface.

## Interface
Parameters:
- `WORD_SIZE`, 32, data and address width
- `DEPTH`, 4, buffer entries (power of two, ≥2)
- `PTR_W`, 2, log2(DEPTH)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `we_mem`  in  1  commit write strobe from reorder buffer
- `ws_mem`  in  WORD_SIZE  commit write address
- `wd_mem`  in  WORD_SIZE  commit write data
- `full`  out  1  count == DEPTH; reorder buffer must not commit a store while high
- `empty`  out  1  count == 0
- `count`  out  PTR_W+1  occupied entries
- `overflow`  out  1  sticky: a write arrived while full and was dropped
- `mem_req`  out  1  head entry valid, request to memory
- `mem_addr`  out  WORD_SIZE  head address
- `mem_wdata`  out  WORD_SIZE  head data
- `mem_ack`  in  1  memory accepted head this cycle
- `rd_addr`  in  WORD_SIZE  load lookup address
- `rd_hit`  out  1  some valid entry matches `rd_addr`
- `rd_data`  out  WORD_SIZE  data of youngest matching entry; 0 when no hit

## Operation
- Circular FIFO: head pointer, tail pointer, count; entries hold {addr, data}.
- Push: `we_mem && !full` writes {ws_mem, wd_mem} at tail, tail+1 mod DEPTH.
- Push while full: dropped, `overflow` set; cleared only by `reset`. No mem_ack bypass: `full` is evaluated before same-cycle pop.
- Pop: `mem_req && mem_ack` at posedge advances head. `mem_ack` with `mem_req` low is ignored.
- Push and pop same cycle: both occur, count unchanged.
- `mem_req = !empty`, driven from registered state; `mem_addr`/`mem_wdata` are head contents and stay stable while `mem_req` is high without `mem_ack`.
- Drain order equals commit order; no reordering.
- Forwarding (combinational): compare `rd_addr` against all valid entries; on multiple matches select the youngest (nearest tail). Same-cycle incoming write is not visible until next cycle.
- Reset values: head=tail=0, count=0, `empty`=1, `full`=0, `overflow`=0, `mem_req`=0, `rd_hit`=0, `rd_data`=0; `mem_addr`/`mem_wdata` don't-care while `mem_req`=0. Reset mid-handshake discards all entries; a pending ack is not waited for.

## Timing
- `we_mem` at edge N → entry visible (count, `rd_hit`, `mem_req` if previously empty) after edge N.
- Minimum residency one cycle: push at N, earliest pop at N+1 with ack.
- Sustained throughput one store/cycle when memory acks every cycle.
- `full`, `empty`, `count` purely registered-state-derived; no combinational path from `we_mem` or `mem_ack` to any output.
- `rd_hit`/`rd_data` combinational from `rd_addr` and state.

## Configuration
- `WBUF_COALESCE_EN` defined: a push whose address matches a valid non-head entry overwrites that entry's data (youngest match) instead of allocating; count unchanged; accepted even when `full`, so no overflow. Head is never overwritten (it may be under request); a match only at head allocates normally.
- Undefined: every accepted push allocates a new entry; duplicates drain in order.

## Test plan
- Reset then idle: `empty`=1, `mem_req`=0, `count`=0, `rd_hit`=0 with `rd_addr`=0x10.
- Push A=0x10/D=0x11, B=0x20/D=0x22 back-to-back, `mem_ack` held 0: `count`=2, `mem_addr`=0x10 stable; ack one cycle → `mem_addr`=0x20, `count`=1.
- Fill 4 entries, push fifth (0x50) while full: `full`=1, `overflow`=1, drained addresses are the first four in order, 0x50 never appears.
- Push 0x30/0xAA then 0x30/0xBB (coalescing off), `rd_addr`=0x30: `rd_hit`=1, `rd_data`=0xBB, `count`=2, memory receives 0xAA then 0xBB.
- With `WBUF_COALESCE_EN`: push 0x40/1, 0x30/0xAA, 0x30/0xBB: `count`=2, memory receives 0x40/1 then 0x30/0xBB only.
- Push with `mem_ack`=1 every cycle for 8 cycles: `count` stays ≤1 after first cycle, 8 writes drained in order; assert `reset` mid-stream → next cycle `empty`=1, `mem_req`=0.

Source files
------------

// File: rtl/commit_write_buffer.sv
// Store-commit write buffer: FIFO of committed stores drained over mem_req/mem_ack, with youngest-match load forwarding.
// Writes while full are dropped and flag overflow; defining WBUF_COALESCE_EN merges same-address stores into non-head entries.
module commit_write_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_mem,
  input  logic [WORD_SIZE-1:0] ws_mem,
  input  logic [WORD_SIZE-1:0] wd_mem,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_W:0]       count,
  output logic                 overflow,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] rd_addr,
  output logic                 rd_hit,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] addr_q [DEPTH];
  logic [WORD_SIZE-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W:0]       cnt;
  logic                 ovf;

  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 coalesce;
  logic [PTR_W-1:0]     fwd_idx;

  assign count     = cnt;
  assign full      = (cnt == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign overflow  = ovf;
  assign mem_req   = !empty;
  assign mem_addr  = addr_q[head];
  assign mem_wdata = data_q[head];

  assign pop = mem_req && mem_ack;

`ifdef WBUF_COALESCE_EN
  logic             coal_hit;
  logic [PTR_W-1:0] coal_idx;
  logic [PTR_W-1:0] cl_idx;

  // Head is excluded: it may be mid-handshake, so its data must not change.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    cl_idx   = '0;
    for (int i = 1; i < DEPTH; i++) begin
      cl_idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt) && (addr_q[cl_idx] == ws_mem)) begin
        coal_hit = 1'b1;
        coal_idx = cl_idx;
      end
    end
  end

  assign coalesce = we_mem && coal_hit;
`else
  assign coalesce = 1'b0;
`endif

  // full is taken from registered state, so a same-cycle ack does not make room.
  assign push = we_mem && !full && !coalesce;
  assign drop = we_mem && full && !coalesce;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt) && (addr_q[fwd_idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= ws_mem;
      data_q[tail] <= wd_mem;
    end
`ifdef WBUF_COALESCE_EN
    if (coalesce) begin
      data_q[coal_idx] <= wd_mem;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_write_buffer.sv
// Randomized scoreboard bench for commit_write_buffer against a queue-based reference model.
module tb_commit_write_buffer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         we_mem;
  logic [W-1:0] ws_mem;
  logic [W-1:0] wd_mem;
  logic         full;
  logic         empty;
  logic [P:0]   count;
  logic         overflow;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack;
  logic [W-1:0] rd_addr;
  logic         rd_hit;
  logic [W-1:0] rd_data;

  always #5 clk = ~clk;

  commit_write_buffer #(.WORD_SIZE(W), .DEPTH(D), .PTR_W(P)) dut (
    .clk(clk), .reset(reset), .we_mem(we_mem), .ws_mem(ws_mem), .wd_mem(wd_mem),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data)
  );

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    int           id;
  } ent_t;

  ent_t mdl[$];   // buffer contents, oldest first
  ent_t sb_q[$];  // expected drain sequence
  int   next_id = 0;
  bit   m_ovf = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit   pop;
    bit   coal;
    ent_t e;
    if (reset) begin
      mdl.delete();
      sb_q.delete();
      m_ovf = 1'b0;
      return;
    end
    pop  = (mdl.size() != 0) && mem_ack;
    coal = 1'b0;
`ifdef WBUF_COALESCE_EN
    if (we_mem) begin
      for (int i = mdl.size() - 1; i >= 1; i--) begin
        if (!coal && mdl[i].addr == ws_mem) begin
          coal = 1'b1;
          mdl[i].data = wd_mem;
          foreach (sb_q[j]) if (sb_q[j].id == mdl[i].id) sb_q[j].data = wd_mem;
        end
      end
    end
`endif
    if (we_mem && !coal) begin
      if (mdl.size() == D) begin
        m_ovf = 1'b1;
      end else begin
        e.addr = ws_mem;
        e.data = wd_mem;
        e.id   = next_id;
        next_id++;
        mdl.push_back(e);
        sb_q.push_back(e);
      end
    end
    if (pop) void'(mdl.pop_front());
  endtask

  task automatic check_state();
    bit           eh;
    logic [W-1:0] ed;
    chk("count", W'(count), mdl.size());
    chk("full", W'(full), (mdl.size() == D) ? 1 : 0);
    chk("empty", W'(empty), (mdl.size() == 0) ? 1 : 0);
    chk("mem_req", W'(mem_req), (mdl.size() != 0) ? 1 : 0);
    chk("overflow", W'(overflow), W'(m_ovf));
    if (mdl.size() != 0) begin
      chk("head_addr", mem_addr, mdl[0].addr);
      chk("head_data", mem_wdata, mdl[0].data);
    end
    eh = 1'b0;
    ed = '0;
    foreach (mdl[i]) begin
      if (mdl[i].addr == rd_addr) begin
        eh = 1'b1;
        ed = mdl[i].data;
      end
    end
    chk("rd_hit", W'(rd_hit), W'(eh));
    chk("rd_data", rd_data, ed);
  endtask

  task automatic cyc(input bit r, input bit we, input logic [W-1:0] a, input logic [W-1:0] d,
                     input bit ack, input logic [W-1:0] ra);
    @(posedge clk);
    model_edge();
    #1;
    reset   = r;
    we_mem  = we;
    ws_mem  = a;
    wd_mem  = d;
    mem_ack = ack;
    rd_addr = ra;
    @(negedge clk);
    check_state();
  endtask

  // Drain monitor: inputs are stable at negedge, so a visible req+ack is taken on the next posedge.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_req && mem_ack) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL drain_unexpected: got addr 0x%0h data 0x%0h, expected no drain", mem_addr, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          chk("drain_addr", mem_addr, e.addr);
          chk("drain_data", mem_wdata, e.data);
        end
      end
    end
  end

  function automatic logic [W-1:0] pick_addr();
    return W'(32'h10 * $urandom_range(1, 7));
  endfunction

  initial begin
    reset = 1'b1; we_mem = 1'b0; ws_mem = '0; wd_mem = '0; mem_ack = 1'b0; rd_addr = '0;

    cyc(1, 0, 0, 0, 0, 32'h10);
    cyc(1, 0, 0, 0, 0, 32'h10);
    cyc(0, 0, 0, 0, 0, 32'h10);
    cyc(0, 0, 0, 0, 1, 32'h10);

    // Two back-to-back pushes held, then one ack.
    cyc(0, 1, 32'h10, 32'h11, 0, 32'h10);
    cyc(0, 1, 32'h20, 32'h22, 0, 32'h20);
    cyc(0, 0, 0, 0, 0, 32'h10);
    cyc(0, 0, 0, 0, 0, 32'h20);
    cyc(0, 0, 0, 0, 1, 32'h10);
    cyc(0, 0, 0, 0, 0, 32'h20);
    cyc(0, 0, 0, 0, 1, 32'h20);
    cyc(0, 0, 0, 0, 0, 32'h20);

    // Fill, push a fifth while full, then drain.
    for (int i = 1; i <= 5; i++) cyc(0, 1, W'(32'h10 * i), W'(32'h100 + i), 0, 32'h50);
    cyc(0, 0, 0, 0, 0, 32'h40);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 32'h50);

    // Same-address stores; forwarding must return the younger data.
    cyc(0, 1, 32'h30, 32'hAA, 0, 32'h30);
    cyc(0, 1, 32'h30, 32'hBB, 0, 32'h30);
    cyc(0, 0, 0, 0, 0, 32'h30);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 32'h30);

    cyc(0, 1, 32'h40, 32'h1, 0, 32'h40);
    cyc(0, 1, 32'h30, 32'hAA, 0, 32'h30);
    cyc(0, 1, 32'h30, 32'hBB, 0, 32'h30);
    cyc(0, 0, 0, 0, 0, 32'h30);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 32'h30);

    // Streaming with ack every cycle, then reset mid-stream.
    for (int i = 0; i < 8; i++) cyc(0, 1, W'(32'h200 + 4 * i), W'(32'hC0 + i), 1, W'(32'h200 + 4 * i));
    cyc(0, 1, 32'h300, 32'hD0, 1, 32'h300);
    cyc(0, 1, 32'h304, 32'hD1, 1, 32'h300);
    cyc(1, 1, 32'h308, 32'hD2, 1, 32'h300);
    cyc(0, 0, 0, 0, 0, 32'h300);
    cyc(0, 0, 0, 0, 1, 32'h308);

    for (int i = 0; i < 400; i++) begin
      cyc(0, ($urandom_range(0, 9) < 6), pick_addr(), W'($urandom), ($urandom_range(0, 1) == 1), pick_addr());
    end

    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, pick_addr());
    cyc(0, 0, 0, 0, 0, pick_addr());
    @(posedge clk);
    #1;
    chk("drains_outstanding", W'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
